// File: rtl/mac_chan_mux.sv
// mac_chan_mux: per-channel TX FIFOs with a round-robin arbiter feeding one
// tagged MAC word stream, plus an RX path that strips the channel tag and
// steers each word to a one-hot per-channel strobe.
module mac_chan_mux #(
    parameter int DATA_W = 128,
    parameter int CH     = 4,
    parameter int DEPTH  = 8,
    localparam int PAY_W = DATA_W - 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CH*PAY_W-1:0]   tx_data_i,
    input  logic [CH-1:0]         tx_valid_i,
    output logic [CH-1:0]         tx_ready_o,
    output logic [CH-1:0]         tx_overflow_o,
    output logic [DATA_W-1:0]     mac_tx_data_o,
    output logic                  mac_tx_valid_o,
    input  logic                  mac_tx_ready_i,
    input  logic [DATA_W-1:0]     mac_rx_data_i,
    input  logic                  mac_rx_valid_i,
    output logic [PAY_W-1:0]      rx_data_o,
    output logic [CH-1:0]         rx_valid_o,
    output logic [15:0]           rx_drop_cnt_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // Per-channel FIFO storage and control
    logic [PAY_W-1:0] fifo_mem [CH][DEPTH];
    logic [AW-1:0]    wr_ptr   [CH];
    logic [AW-1:0]    rd_ptr   [CH];
    logic [CW-1:0]    cnt      [CH];
    logic [CH-1:0]    fifo_rdy;
    logic [CH-1:0]    wr_en;
    logic [CH-1:0]    not_empty;
    logic [CH-1:0]    pop;
    logic [CH-1:0]    ovf;

    // Arbiter
    logic [7:0]       last_grant;
    logic             grant_vld;
    logic [7:0]       grant_idx;
    logic [PAY_W-1:0] grant_data;
    logic             load_p0;

    // TX output stage
    logic              tx_vld_p1;
    logic [DATA_W-1:0] tx_data_p1;

    // RX path
    logic [7:0]       rx_id_p0;
    logic             rx_hit_p0;
    logic [CH-1:0]    rx_hot_p0;
    logic [CH-1:0]    rx_vld_p1;
    logic [PAY_W-1:0] rx_data_p1;
    logic [15:0]      drop_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // FIFO status: full only when the registered count reaches DEPTH
    always_comb begin
        fifo_rdy  = '0;
        wr_en     = '0;
        not_empty = '0;
        for (int c = 0; c < CH; c++) begin
            fifo_rdy[c]  = (cnt[c] != CW'(DEPTH));
            wr_en[c]     = tx_valid_i[c] && fifo_rdy[c];
            not_empty[c] = (cnt[c] != '0);
        end
    end

    // Round-robin pick: lowest non-empty channel above last_grant, else lowest overall
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        for (int c = CH - 1; c >= 0; c--) begin
            if (not_empty[c]) begin
                grant_vld = 1'b1;
                grant_idx = 8'(c);
            end
        end
        for (int c = CH - 1; c >= 0; c--) begin
            if (not_empty[c] && (c > int'(last_grant))) begin
                grant_idx = 8'(c);
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (int'(grant_idx) == c) begin
                grant_data = fifo_mem[c][rd_ptr[c]];
            end
        end
    end

    // Output register reloads when empty or when its word is taken this cycle
    always_comb begin
        load_p0 = !tx_vld_p1 || mac_tx_ready_i;
        pop     = '0;
        for (int c = 0; c < CH; c++) begin
            pop[c] = load_p0 && grant_vld && (int'(grant_idx) == c);
        end
    end

    // Stage p0: FIFO pointers, occupancy and sticky overflow flags
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
            ovf <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (wr_en[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
                if (pop[c])   rd_ptr[c] <= rd_ptr[c] + AW'(1);
                cnt[c] <= cnt[c] + CW'(wr_en[c]) - CW'(pop[c]);
                if (tx_valid_i[c] && !fifo_rdy[c]) ovf[c] <= 1'b1;
            end
        end
    end

    // FIFO storage write; contents are don't-care until the pointers move
    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (!reset && wr_en[c]) begin
                fifo_mem[c][wr_ptr[c]] <= tx_data_i[c*PAY_W +: PAY_W];
            end
        end
    end

    // Stage p1: tagged TX output register and arbiter history
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_vld_p1  <= 1'b0;
            tx_data_p1 <= '0;
            last_grant <= 8'(CH - 1);
        end else if (load_p0) begin
            tx_vld_p1 <= grant_vld;
            if (grant_vld) begin
                tx_data_p1 <= {grant_idx, grant_data};
                last_grant <= grant_idx;
            end
        end
    end

    // RX tag decode
    always_comb begin
        rx_id_p0  = mac_rx_data_i[DATA_W-1 -: 8];
        rx_hit_p0 = (int'(rx_id_p0) < CH);
        rx_hot_p0 = '0;
        for (int c = 0; c < CH; c++) begin
            rx_hot_p0[c] = (int'(rx_id_p0) == c);
        end
    end

    // Stage p1: RX steering register and saturating drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_vld_p1  <= '0;
            rx_data_p1 <= '0;
            drop_cnt   <= '0;
        end else begin
            rx_vld_p1 <= (mac_rx_valid_i && rx_hit_p0) ? rx_hot_p0 : '0;
            if (mac_rx_valid_i && rx_hit_p0) rx_data_p1 <= mac_rx_data_i[PAY_W-1:0];
            if (mac_rx_valid_i && !rx_hit_p0) drop_cnt <= sat_inc16(drop_cnt);
        end
    end

    assign tx_ready_o     = fifo_rdy;
    assign tx_overflow_o  = ovf;
    assign mac_tx_data_o  = tx_data_p1;
    assign mac_tx_valid_o = tx_vld_p1;
    assign rx_data_o      = rx_data_p1;
    assign rx_valid_o     = rx_vld_p1;
    assign rx_drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_mac_chan_mux.sv
// Scoreboard bench for mac_chan_mux: directed stimulus pushes expected TX and
// RX words into queues, independent monitors pop and compare on each transfer.
module tb_mac_chan_mux;

    localparam int DATA_W = 128;
    localparam int CH     = 4;
    localparam int DEPTH  = 8;
    localparam int PAY_W  = DATA_W - 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [CH*PAY_W-1:0] tx_data_i;
    logic [CH-1:0]       tx_valid_i;
    logic [CH-1:0]       tx_ready_o;
    logic [CH-1:0]       tx_overflow_o;
    logic [DATA_W-1:0]   mac_tx_data_o;
    logic                mac_tx_valid_o;
    logic                mac_tx_ready_i;
    logic [DATA_W-1:0]   mac_rx_data_i;
    logic                mac_rx_valid_i;
    logic [PAY_W-1:0]    rx_data_o;
    logic [CH-1:0]       rx_valid_o;
    logic [15:0]         rx_drop_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [127:0] tx_q [$];
    logic [123:0] rx_q [$];
    logic [127:0] tx_exp;
    logic [123:0] rx_exp;

    mac_chan_mux #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_data_i      (tx_data_i),
        .tx_valid_i     (tx_valid_i),
        .tx_ready_o     (tx_ready_o),
        .tx_overflow_o  (tx_overflow_o),
        .mac_tx_data_o  (mac_tx_data_o),
        .mac_tx_valid_o (mac_tx_valid_o),
        .mac_tx_ready_i (mac_tx_ready_i),
        .mac_rx_data_i  (mac_rx_data_i),
        .mac_rx_valid_i (mac_rx_valid_i),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_drop_cnt_o  (rx_drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset          = 1'b1;
        tx_valid_i     = '0;
        tx_data_i      = '0;
        mac_tx_ready_i = 1'b0;
        mac_rx_valid_i = 1'b0;
        mac_rx_data_i  = '0;
        tick;
        tick;
        reset = 1'b0;
        tx_q.delete();
        rx_q.delete();
    endtask

    // TX monitor: every accepted output word must match the head of the queue
    always @(negedge clk) begin
        if (!reset && mac_tx_valid_o && mac_tx_ready_i) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %h, expected no word", mac_tx_data_o);
            end else begin
                tx_exp = tx_q.pop_front();
                check("tx_word", mac_tx_data_o, tx_exp);
            end
        end
    end

    // RX monitor: every strobe must match the head of the queue
    always @(negedge clk) begin
        if (!reset && rx_valid_o != '0) begin
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %h/%h, expected no word", rx_valid_o, rx_data_o);
            end else begin
                rx_exp = rx_q.pop_front();
                check("rx_word", 128'({rx_valid_o, rx_data_o}), 128'(rx_exp));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [PAY_W-1:0] pay;

        // Reset values
        do_reset;
        check("rst_tx_valid", 128'(mac_tx_valid_o), 128'(0));
        check("rst_tx_data",  128'(mac_tx_data_o),  128'(0));
        check("rst_rx_valid", 128'(rx_valid_o),     128'(0));
        check("rst_rx_data",  128'(rx_data_o),      128'(0));
        check("rst_drop",     128'(rx_drop_cnt_o),  128'(0));
        check("rst_ovf",      128'(tx_overflow_o),  128'(0));
        check("rst_ready",    128'(tx_ready_o),     128'(4'b1111));

        // Single word on channel 2, two-edge latency, one cycle of valid
        mac_tx_ready_i = 1'b1;
        tx_data_i[2*PAY_W +: PAY_W] = 120'hAB;
        tx_valid_i = 4'b0100;
        tx_q.push_back({8'h02, 120'hAB});
        tick;
        check("lat_k1_valid", 128'(mac_tx_valid_o), 128'(0));
        tx_valid_i = '0;
        tick;
        check("lat_k2_valid", 128'(mac_tx_valid_o), 128'(1));
        check("lat_k2_id",    128'(mac_tx_data_o[127:120]), 128'(8'h02));
        check("lat_k2_pay",   128'(mac_tx_data_o[119:0]),   128'(120'hAB));
        tick;
        check("lat_one_cycle", 128'(mac_tx_valid_o), 128'(0));

        // Round-robin over 3 words per channel, no bubbles once ready rises
        do_reset;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < CH; c++) begin
                pay = 120'(16'hC000 + c * 16 + r);
                tx_data_i[c*PAY_W +: PAY_W] = pay;
                tx_q.push_back({8'(c), pay});
            end
            tx_valid_i = 4'b1111;
            tick;
        end
        tx_valid_i = '0;
        tick;
        tick;
        tick;
        mac_tx_ready_i = 1'b1;
        for (int j = 0; j < 12; j++) begin
            check("rr_no_bubble", 128'(mac_tx_valid_o), 128'(1));
            tick;
        end
        check("rr_end_valid", 128'(mac_tx_valid_o), 128'(0));
        check("rr_queue_empty", 128'(tx_q.size()), 128'(0));

        // Backpressure: stream channel 1 for 11 cycles with ready low
        mac_tx_ready_i = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            pay = 120'(12'h100 + i);
            tx_data_i[1*PAY_W +: PAY_W] = pay;
            tx_valid_i = 4'b0010;
            if (i <= 9) tx_q.push_back({8'h01, pay});
            tick;
            check("bp_ready", 128'(tx_ready_o[1]),    128'(i < 9));
            check("bp_ovf",   128'(tx_overflow_o[1]), 128'(i >= 10));
            if (i >= 2) begin
                check("bp_hold_valid", 128'(mac_tx_valid_o), 128'(1));
                check("bp_hold_data",  mac_tx_data_o, {8'h01, 120'h101});
            end
        end
        tx_valid_i = '0;
        mac_tx_ready_i = 1'b1;
        repeat (12) tick;
        check("bp_drained",    128'(tx_q.size()),   128'(0));
        check("bp_ovf_sticky", 128'(tx_overflow_o), 128'(4'b0010));
        check("bp_ready_back", 128'(tx_ready_o),    128'(4'b1111));

        // RX steering, drop counting and saturation
        mac_rx_data_i  = {8'h03, 120'h333};
        mac_rx_valid_i = 1'b1;
        rx_q.push_back({4'b1000, 120'h333});
        tick;
        check("rx3_valid", 128'(rx_valid_o), 128'(4'b1000));
        mac_rx_data_i = {8'h07, 120'h777};
        tick;
        check("rx7_valid",     128'(rx_valid_o),    128'(0));
        check("rx7_drop",      128'(rx_drop_cnt_o), 128'(1));
        check("rx7_data_hold", 128'(rx_data_o),     128'(120'h333));
        mac_rx_valid_i = 1'b0;
        mac_rx_data_i  = {8'h01, 120'h999};
        tick;
        check("rx_idle_valid", 128'(rx_valid_o), 128'(0));
        check("rx_idle_hold",  128'(rx_data_o),  128'(120'h333));
        mac_rx_valid_i = 1'b1;
        for (int n = 0; n < 70000; n++) begin
            mac_rx_data_i = {8'(4 + n % 252), 120'(n)};
            tick;
            if (n == 99) check("rx_drop_mid", 128'(rx_drop_cnt_o), 128'(101));
        end
        check("rx_drop_sat", 128'(rx_drop_cnt_o), 128'(16'hFFFF));
        mac_rx_data_i = {8'h00, 120'h55};
        rx_q.push_back({4'b0001, 120'h55});
        tick;
        check("rx0_valid", 128'(rx_valid_o), 128'(4'b0001));
        mac_rx_valid_i = 1'b0;
        tick;
        check("rx_drop_final", 128'(rx_drop_cnt_o), 128'(16'hFFFF));
        check("rx_queue_empty", 128'(rx_q.size()), 128'(0));

        // Reset mid-stream with all FIFOs occupied and output valid
        mac_tx_ready_i = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < CH; c++) begin
                tx_data_i[c*PAY_W +: PAY_W] = 120'(16'hD000 + c * 16 + r);
            end
            tx_valid_i = 4'b1111;
            tick;
        end
        tx_valid_i = '0;
        tick;
        check("mid_pre_valid", 128'(mac_tx_valid_o), 128'(1));
        check("mid_pre_ovf",   128'(tx_overflow_o),  128'(4'b0010));
        reset          = 1'b1;
        mac_tx_ready_i = 1'b1;
        tx_valid_i     = 4'b1111;
        tx_q.delete();
        tick;
        reset      = 1'b0;
        tx_valid_i = '0;
        check("mid_valid", 128'(mac_tx_valid_o), 128'(0));
        check("mid_data",  128'(mac_tx_data_o),  128'(0));
        check("mid_ready", 128'(tx_ready_o),     128'(4'b1111));
        check("mid_ovf",   128'(tx_overflow_o),  128'(0));
        for (int j = 0; j < 10; j++) begin
            tick;
            check("mid_no_stale", 128'(mac_tx_valid_o), 128'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
